// File: rtl/sram_controller_pkg.sv
// Shared definitions for the SRAM bridge.
// Provides the access-sequencer state encoding and the CPU byte address that
// maps to SRAM word 0 (also reused by the pipeline top for its address map).
package sram_controller_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOW  = 2'd1,
        HIGH = 2'd2,
        DONE = 2'd3
    } state_t;

    localparam int unsigned DEFAULT_ADDR_BASE = 1024;

endpackage

// File: rtl/sram_controller.sv
// Multi-cycle bridge between the MEM stage data port and a 16-bit
// asynchronous SRAM. Each 32-bit access is split into a low and a high
// half-word access of WAIT_CYCLES clocks each; ready stays low meanwhile.
// Ports:
//   clock, reset            rising-edge clock, synchronous active-high reset
//   rd_en, wr_en            load / store request (store wins if both set)
//   address, write_data     CPU byte address and store value, held by MEM
//   read_data               load result, updated only by reads
//   ready                   no access pending, or final (DONE) cycle
//   sram_addr               half-word address to the SRAM
//   sram_dq_out/_in/_oe     SRAM data bus out, in, and output enable
//   sram_we_n               SRAM write strobe, active-low
module sram_controller
    import sram_controller_pkg::*;
#(
    parameter int unsigned LEN         = 32,
    parameter int unsigned ADDR_BASE   = DEFAULT_ADDR_BASE,
    parameter int unsigned SRAM_ADDR_W = 18,
    parameter int unsigned SRAM_DATA_W = 16,
    parameter int unsigned WAIT_CYCLES = 5
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   rd_en,
    input  logic                   wr_en,
    input  logic [LEN-1:0]         address,
    input  logic [LEN-1:0]         write_data,
    output logic [LEN-1:0]         read_data,
    output logic                   ready,
    output logic [SRAM_ADDR_W-1:0] sram_addr,
    output logic [SRAM_DATA_W-1:0] sram_dq_out,
    input  logic [SRAM_DATA_W-1:0] sram_dq_in,
    output logic                   sram_dq_oe,
    output logic                   sram_we_n
);

    localparam int unsigned      CNT_W    = $clog2(WAIT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_CYCLES - 1);

    state_t                 state;
    logic [CNT_W-1:0]       counter;
    logic [CNT_W-1:0]       cnt_next;
    logic [LEN-1:0]         off;
    logic [SRAM_ADDR_W-1:0] lo_addr;
    logic [SRAM_ADDR_W-1:0] hi_addr;
    logic [SRAM_DATA_W-1:0] wd_lo;
    logic [SRAM_DATA_W-1:0] wd_hi;
    logic                   is_read;
    logic                   we_mid;
    logic                   unused_off;

    always_comb begin
        off        = address - LEN'(ADDR_BASE);
        // {word, half} truncated to SRAM_ADDR_W bits; byte offset bits dropped
        lo_addr    = {off[SRAM_ADDR_W:2], 1'b0};
        hi_addr    = {off[SRAM_ADDR_W:2], 1'b1};
        unused_off = ^{off[LEN-1:SRAM_ADDR_W+1], off[1:0]};
        wd_lo      = write_data[SRAM_DATA_W-1:0];
        wd_hi      = write_data[2*SRAM_DATA_W-1:SRAM_DATA_W];
        is_read    = rd_en & ~wr_en;
        cnt_next   = counter + 1'b1;
        // Outputs are registered, so the strobe is decided from the counter
        // value of the coming cycle: released on the last cycle of a phase.
        we_mid     = wr_en & (cnt_next != CNT_LAST);
    end

    assign ready = (state == DONE) | ((state == IDLE) & ~rd_en & ~wr_en);

    always_ff @(posedge clock) begin
        if (reset) begin
            state       <= IDLE;
            counter     <= '0;
            read_data   <= '0;
            sram_addr   <= '0;
            sram_dq_out <= '0;
            sram_dq_oe  <= 1'b0;
            sram_we_n   <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    counter <= '0;
                    if (rd_en | wr_en) begin
                        state       <= LOW;
                        sram_addr   <= lo_addr;
                        sram_dq_out <= wd_lo;
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= ~wr_en;
                    end
                end
                LOW: begin
                    if (counter == CNT_LAST) begin
                        if (is_read) read_data[SRAM_DATA_W-1:0] <= sram_dq_in;
                        state       <= HIGH;
                        counter     <= '0;
                        sram_addr   <= hi_addr;
                        sram_dq_out <= wd_hi;
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= ~wr_en;
                    end else begin
                        counter     <= cnt_next;
                        sram_addr   <= lo_addr;
                        sram_dq_out <= wd_lo;
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= ~we_mid;
                    end
                end
                HIGH: begin
                    if (counter == CNT_LAST) begin
                        if (is_read) read_data[2*SRAM_DATA_W-1:SRAM_DATA_W] <= sram_dq_in;
                        state      <= DONE;
                        counter    <= '0;
                        sram_dq_oe <= 1'b0;
                        sram_we_n  <= 1'b1;
                    end else begin
                        counter     <= cnt_next;
                        sram_addr   <= hi_addr;
                        sram_dq_out <= wd_hi;
                        sram_dq_oe  <= wr_en;
                        sram_we_n   <= ~we_mid;
                    end
                end
                DONE: begin
                    state      <= IDLE;
                    counter    <= '0;
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                end
                default: begin
                    state      <= IDLE;
                    counter    <= '0;
                    sram_dq_oe <= 1'b0;
                    sram_we_n  <= 1'b1;
                end
            endcase
        end
    end

endmodule
